// File: rtl/parity_accum.sv
// Frame parity accumulator: XOR-reduces a stream of words into one parity bit per frame,
// optionally compares it against an expected bit, and presents the result with a valid/ready handshake.
module parity_accum #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int MODE      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             chk_en,
    input  logic             chk_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_err,
    output logic [7:0]       out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] FRAME_LEN_W = 8'(FRAME_LEN);
    localparam logic       INVERT      = (MODE != 0);

    state_t     state, state_next;
    logic       acc, acc_next;
    logic [7:0] count, count_next;
    logic       parity_q, err_q;
    logic [7:0] count_q;

    logic       take;
    logic       give;
    logic       closing;
    logic       load_result;
    logic       word_par;
    logic       frame_par;
    logic [7:0] count_inc;

    assign word_par  = ^in_data;
    assign count_inc = count + 8'd1;
    // Polarity is folded in before the check so out_err always compares what is actually reported.
    assign frame_par = (acc ^ word_par) ^ INVERT;

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        in_ready    = (state != HOLD);
        out_valid   = (state == HOLD);
        take        = in_valid & in_ready;
        give        = out_valid & out_ready;
        closing     = take & (in_last | (count_inc == FRAME_LEN_W));
        state_next  = state;
        acc_next    = acc;
        count_next  = count;
        load_result = 1'b0;

        case (state)
            IDLE, ACCUM: begin
                if (take) begin
                    acc_next   = acc ^ word_par;
                    count_next = count_inc;
                    if (closing) begin
                        state_next  = HOLD;
                        load_result = 1'b1;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            HOLD: begin
                // The handshake cycle itself never accepts a word; in_ready is already low here.
                if (give) begin
                    state_next = IDLE;
                    acc_next   = 1'b0;
                    count_next = 8'd0;
                end
            end
            default: begin
                state_next = IDLE;
                acc_next   = 1'b0;
                count_next = 8'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= 1'b0;
            count    <= 8'd0;
            parity_q <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            count <= count_next;
            if (load_result) begin
                parity_q <= frame_par;
                err_q    <= chk_en & (frame_par ^ chk_bit);
                count_q  <= count_inc;
            end
        end
    end

    assign out_parity = parity_q;
    assign out_err    = err_q;
    assign out_count  = count_q;

endmodule

// File: tb/tb_parity_accum.sv
// Self-checking bench: drives an even-parity and an odd-parity instance in lockstep and
// compares both against a frame-level reference model plus a table of directed frames.
module tb_parity_accum;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             chk_en;
    logic             chk_bit;
    logic             out_ready;

    logic       in_ready0, out_valid0, out_parity0, out_err0;
    logic [7:0] out_count0;
    logic       in_ready1, out_valid1, out_parity1, out_err1;
    logic [7:0] out_count1;

    parity_accum #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .chk_en(chk_en), .chk_bit(chk_bit),
        .out_valid(out_valid0), .out_ready(out_ready), .out_parity(out_parity0),
        .out_err(out_err0), .out_count(out_count0)
    );

    parity_accum #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .chk_en(chk_en), .chk_bit(chk_bit),
        .out_valid(out_valid1), .out_ready(out_ready), .out_parity(out_parity1),
        .out_err(out_err1), .out_count(out_count1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the list of per-word popcounts; parity is the total mod 2.
    bit m_hold;
    int m_ones[$];
    bit m_par;
    bit m_err0;
    bit m_err1;
    int m_cnt;

    task automatic compare_outputs();
        check("in_ready_m0", in_ready0, !m_hold);
        check("in_ready_m1", in_ready1, !m_hold);
        check("out_valid_m0", out_valid0, m_hold);
        check("out_valid_m1", out_valid1, m_hold);
        if (m_hold) begin
            check("parity_m0", out_parity0, m_par);
            check("parity_m1", out_parity1, !m_par);
            check("err_m0", out_err0, m_err0);
            check("err_m1", out_err1, m_err1);
            check("count_m0", out_count0, m_cnt);
            check("count_m1", out_count1, m_cnt);
        end
    endtask

    // Compare the current cycle, then advance the model across the rising edge.
    task automatic cycle();
        int total;
        compare_outputs();
        @(posedge clk);
        if (!rst_n) begin
            m_hold = 1'b0;
            m_ones.delete();
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            m_ones.push_back($countones(in_data));
            if (in_last || m_ones.size() == FRAME_LEN) begin
                total = 0;
                foreach (m_ones[i]) total += m_ones[i];
                m_par  = (total % 2) == 1;
                m_err0 = chk_en && (m_par != chk_bit);
                m_err1 = chk_en && ((!m_par) != chk_bit);
                m_cnt  = m_ones.size();
                m_hold = 1'b1;
                m_ones.delete();
            end
        end
        #1;
    endtask

    typedef struct {
        logic [3:0][7:0] w;     // w[0] is sent first
        int              n;
        bit              last;
        bit              ce;
        bit              cb;
        bit              par0;
        bit              err0;
        bit              par1;
        bit              err1;
        int              cnt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic p_hold;
        logic e_hold;
        logic [7:0] c_hold;

        tbl[0] = '{{8'hFF, 8'h00, 8'h03, 8'h01}, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4};
        tbl[1] = '{{8'h00, 8'h00, 8'h00, 8'hA5}, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        tbl[2] = '{{8'h00, 8'h00, 8'h00, 8'h80}, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4};
        tbl[3] = '{{8'h00, 8'h00, 8'h01, 8'h03}, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2};
        tbl[4] = '{{8'h00, 8'h0F, 8'h7F, 8'hFF}, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        chk_en = 1'b0; chk_bit = 1'b0; out_ready = 1'b0;
        m_hold = 1'b0; m_par = 1'b0; m_err0 = 1'b0; m_err1 = 1'b0; m_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", in_ready0, 1);
        check("rst_out_valid", out_valid0, 0);
        check("rst_parity", out_parity0, 0);
        check("rst_err", out_err0, 0);
        check("rst_count", out_count0, 0);

        // Directed frames; chk fields on non-closing words are deliberately wrong to show they are ignored.
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                bit fin;
                fin      = (j == tbl[i].n - 1);
                in_valid = 1'b1;
                in_data  = tbl[i].w[j];
                in_last  = fin ? tbl[i].last : 1'b0;
                chk_en   = fin ? tbl[i].ce : 1'b1;
                chk_bit  = fin ? tbl[i].cb : ~tbl[i].cb;
                cycle();
            end
            in_valid = 1'b0; in_last = 1'b0; chk_en = 1'b0; chk_bit = 1'b0;
            check("tbl_valid", out_valid0, 1);
            check("tbl_par_m0", out_parity0, tbl[i].par0);
            check("tbl_err_m0", out_err0, tbl[i].err0);
            check("tbl_par_m1", out_parity1, tbl[i].par1);
            check("tbl_err_m1", out_err1, tbl[i].err1);
            check("tbl_count", out_count0, tbl[i].cnt);
            if (!tbl[i].last) begin
                in_valid = 1'b1; in_data = 8'h55;
                check("overflow_ready", in_ready0, 0);
                cycle();
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            cycle();
            out_ready = 1'b0;
        end

        // Stalled result: a word offered throughout HOLD must wait until after the handshake.
        in_valid = 1'b1; in_data = 8'h07; in_last = 1'b1; chk_en = 1'b1; chk_bit = 1'b1;
        cycle();
        in_data = 8'hFF; chk_en = 1'b0; chk_bit = 1'b0;
        p_hold = out_parity0; e_hold = out_err0; c_hold = out_count0;
        check("stall_par_value", p_hold, 1);
        for (int k = 0; k < 4; k++) begin
            out_ready = (k == 3);
            check("stall_valid", out_valid0, 1);
            check("stall_ready", in_ready0, 0);
            check("stall_par", out_parity0, p_hold);
            check("stall_err", out_err0, e_hold);
            check("stall_count", out_count0, c_hold);
            cycle();
        end
        out_ready = 1'b0;
        check("post_hs_ready", in_ready0, 1);
        check("post_hs_valid", out_valid0, 0);
        cycle();
        check("post_hs_count", out_count0, 1);
        check("post_hs_par", out_parity0, 0);
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

        // Reset mid-frame drops the partial frame.
        in_valid = 1'b1; in_last = 1'b0; in_data = 8'h01;
        cycle();
        in_data = 8'h02;
        cycle();
        in_valid = 1'b0; rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("midrst_valid", out_valid0, 0);
        check("midrst_count", out_count0, 0);
        check("midrst_par", out_parity0, 0);
        in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1;
        cycle();
        in_valid = 1'b0; in_last = 1'b0;
        check("midrst_frame_par", out_parity0, 1);
        check("midrst_frame_count", out_count0, 1);
        out_ready = 1'b1;
        cycle();

        // Randomised traffic with occasional resets, checked every cycle by the model.
        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = WIDTH'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            chk_en    = ($urandom_range(0, 1) == 1);
            chk_bit   = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_accum.md
PARITY_ACCUM -- requirements
Module: parity_accum

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (1..32).
REQ-002 Parameter FRAME_LEN, default 4, maximum words per frame (1..255).
REQ-003 Parameter MODE, default 0, result polarity: 0 = even parity (XOR reduction), 1 = odd parity (XNOR reduction).
REQ-004 clk  input  1  single clock; all logic samples on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  in_data, in_last, chk_en and chk_bit are valid this cycle.
REQ-007 in_ready  output  1  block accepts an input word this cycle.
REQ-008 in_data  input  WIDTH  data word.
REQ-009 in_last  input  1  marks the final word of the frame.
REQ-010 chk_en  input  1  check mode, sampled with the final word.
REQ-011 chk_bit  input  1  expected parity, sampled with the final word.
REQ-012 out_valid  output  1  frame result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_parity  output  1  frame parity result.
REQ-015 out_err  output  1  check mismatch flag.
REQ-016 out_count  output  8  number of words in the reported frame.

Function
REQ-017 A transfer occurs on a cycle with in_valid=1 and in_ready=1; an output handshake occurs on a cycle with out_valid=1 and out_ready=1.
REQ-018 FSM states: IDLE (no frame open), ACCUM (frame open), HOLD (result presented).
REQ-019 in_ready=1 in IDLE and ACCUM; in_ready=0 in HOLD.
REQ-020 out_valid=1 only in HOLD; out_parity, out_err and out_count stay stable while out_valid=1.
REQ-021 Running accumulator acc := acc XOR (XOR-reduce of in_data) on each transfer; acc clears to 0 on entry to IDLE.
REQ-022 Word counter increments by 1 per transfer and clears to 0 on entry to IDLE.
REQ-023 IDLE -> ACCUM on a transfer that does not close the frame; IDLE -> HOLD on a transfer that closes the frame.
REQ-024 A transfer closes the frame when in_last=1 or the word counter reaches FRAME_LEN with that word; ACCUM -> HOLD on a closing transfer.
REQ-025 Latency: out_valid rises in the cycle after the closing transfer.
REQ-026 out_parity = final acc when MODE=0; out_parity = NOT final acc when MODE=1.
REQ-027 out_err = chk_en AND (out_parity XOR chk_bit), with chk_en and chk_bit taken from the closing transfer; out_err=0 when chk_en=0.
REQ-028 chk_en and chk_bit on non-closing transfers are ignored.
REQ-029 out_count = number of words in the frame, 1..FRAME_LEN.
REQ-030 HOLD -> IDLE on an output handshake; HOLD is held indefinitely while out_ready=0.
REQ-031 No input word is accepted in the cycle of the output handshake; the next frame starts no earlier than the following cycle.
REQ-032 in_data, in_last, chk_en and chk_bit are ignored when in_valid=0 or in_ready=0.

Reset
REQ-033 rst_n=0 at a rising edge forces IDLE, acc=0, counter=0, out_valid=0, out_parity=0, out_err=0, out_count=0; in_ready=1 from the first cycle after release.
REQ-034 Reset asserted mid-frame or in HOLD discards the partial frame or pending result; no result for that frame is ever presented.

Verification
REQ-035 WIDTH=8, FRAME_LEN=4, MODE=0, words 0x01, 0x03, 0x00, 0xFF, in_last on the 4th -> one cycle later out_valid=1, out_parity=1, out_count=4, out_err=0.
REQ-036 Same stimulus with MODE=1 -> out_parity=0, out_count=4.
REQ-037 Single word 0xA5 with in_last=1, chk_en=1, chk_bit=1 -> out_parity=0, out_err=1, out_count=1.
REQ-038 Four words 0x80, 0x00, 0x00, 0x00 with in_last=0 throughout -> frame auto-closes on the 4th word: out_parity=1, out_count=4; a 5th word offered next cycle is not accepted (in_ready=0).
REQ-039 Result present with out_ready=0 for 3 cycles, then 1 -> out_valid and outputs stable for 4 cycles, in_ready=0 during them, in_ready=1 the cycle after the handshake.
REQ-040 Two words accepted, then rst_n=0 for 1 cycle, then word 0x01 with in_last=1 -> out_parity=1, out_count=1 (pre-reset words excluded).
